// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle 8-bit CPU: opcodes, instruction
// field positions and the branch displacement helper.
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    // Field positions inside the 32-bit instruction word
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 24;
    localparam int RD_HI  = 23;
    localparam int RD_LO  = 16;
    localparam int RS1_HI = 15;
    localparam int RS1_LO = 8;
    localparam int RS2_HI = 7;
    localparam int RS2_LO = 0;

    // Register indices use only the low bits of each field
    localparam int REG_IDX_W = 3;

    // Sign-extend an 8-bit word offset and scale it to a byte displacement
    function automatic logic [31:0] branch_disp(input logic [7:0] offset);
        return {{22{offset[7]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/reg_file_8x8.sv
// Eight 8-bit registers, two combinational read ports, one clocked write port.
// The array regs_q is left at module scope so it can be probed hierarchically.
module reg_file_8x8
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic [7:0]           wr_data,
    input  logic [REG_IDX_W-1:0] rd_addr1,
    input  logic [REG_IDX_W-1:0] rd_addr2,
    output logic [7:0]           rd_data1,
    output logic [7:0]           rd_data2
);

    logic [7:0] regs_q [0:7];
    logic [7:0] regs_d [0:7];

    // Next-state of the array: the addressed register takes the write data
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register storage; reset wins over any write on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: 8'h00};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports see pre-edge contents, so a same-cycle write is not bypassed
    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        rd_data2 = regs_q[rd_addr2];
    end

endmodule

// File: rtl/cpu.sv
// Single-cycle CPU: decode, ALU and PC update are inline; register storage
// lives in reg_file_8x8. Every instruction completes at the next rising edge.
module cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] PC,
    input  logic [31:0] INSTRUCTION
);

    logic [31:0]          pc_q;
    logic [31:0]          pc_d;
    logic [31:0]          pc_plus4_s;
    logic [7:0]           op_s;
    logic [7:0]           offset_s;
    logic [7:0]           imm_s;
    logic [REG_IDX_W-1:0] rd_idx_s;
    logic [REG_IDX_W-1:0] rs1_idx_s;
    logic [REG_IDX_W-1:0] rs2_idx_s;
    logic [4:0]           unused_rs1_hi_s;
    logic [7:0]           rs1_val_s;
    logic [7:0]           rs2_val_s;
    logic                 wr_en_s;
    logic [7:0]           wr_data_s;

    // Field extraction; RD and OFFSET share a field, as do RS2 and IMM
    always_comb begin
        op_s            = INSTRUCTION[OP_HI:OP_LO];
        offset_s        = INSTRUCTION[RD_HI:RD_LO];
        imm_s           = INSTRUCTION[RS2_HI:RS2_LO];
        rd_idx_s        = INSTRUCTION[RD_LO+REG_IDX_W-1:RD_LO];
        rs1_idx_s       = INSTRUCTION[RS1_LO+REG_IDX_W-1:RS1_LO];
        rs2_idx_s       = INSTRUCTION[RS2_LO+REG_IDX_W-1:RS2_LO];
        unused_rs1_hi_s = INSTRUCTION[RS1_HI:RS1_LO+REG_IDX_W];
    end

    reg_file_8x8 u_rf (
        .clk      (CLK),
        .reset    (RESET),
        .wr_en    (wr_en_s),
        .wr_addr  (rd_idx_s),
        .wr_data  (wr_data_s),
        .rd_addr1 (rs1_idx_s),
        .rd_addr2 (rs2_idx_s),
        .rd_data1 (rs1_val_s),
        .rd_data2 (rs2_val_s)
    );

    // ALU result, write enable and next PC for the current instruction
    always_comb begin
        pc_plus4_s = pc_q + 32'd4;
        pc_d       = pc_plus4_s;
        wr_en_s    = 1'b0;
        wr_data_s  = 8'h00;
        case (op_s)
            OP_LOADI: begin
                wr_en_s   = 1'b1;
                wr_data_s = imm_s;
            end
            OP_MOV: begin
                wr_en_s   = 1'b1;
                wr_data_s = rs2_val_s;
            end
            OP_ADD: begin
                wr_en_s   = 1'b1;
                wr_data_s = rs1_val_s + rs2_val_s;
            end
            OP_SUB: begin
                wr_en_s   = 1'b1;
                wr_data_s = rs1_val_s - rs2_val_s;
            end
            OP_AND: begin
                wr_en_s   = 1'b1;
                wr_data_s = rs1_val_s & rs2_val_s;
            end
            OP_OR: begin
                wr_en_s   = 1'b1;
                wr_data_s = rs1_val_s | rs2_val_s;
            end
            OP_J: begin
                pc_d = pc_plus4_s + branch_disp(offset_s);
            end
            OP_BEQ: begin
                if (rs1_val_s == rs2_val_s) begin
                    pc_d = pc_plus4_s + branch_disp(offset_s);
                end else begin
                    pc_d = pc_plus4_s;
                end
            end
            default: begin
                // Undefined opcodes behave as NOP
                pc_d = pc_plus4_s;
            end
        endcase
    end

    // Program counter register; reset abandons the instruction in flight
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC = pc_q;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed vector table, hand-written control
// and reset sequences, and randomized instructions against a behavioural model.
module tb_cpu;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0800_0000;

    logic        CLK;
    logic        RESET;
    logic [31:0] PC;
    logic [31:0] INSTRUCTION;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural reference state
    logic [31:0] m_pc;
    int          m_regs [8];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] exp_pc;
        int          reg_idx;
        logic [7:0]  exp_val;
    } vec_t;

    vec_t vecs [13];

    cpu #(.RESET_PC(RESET_PC)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PC          (PC),
        .INSTRUCTION (INSTRUCTION)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural effect of one edge, written from the instruction-set rules
    task automatic model(input logic [31:0] instr, input logic rst);
        int op, rd, rs1, rs2, imm, off, a, b, res;
        bit wr, taken;
        if (rst) begin
            m_pc = RESET_PC;
            for (int i = 0; i < 8; i++) m_regs[i] = 0;
            return;
        end
        op  = int'(instr[31:24]);
        rd  = int'(instr[23:16]) % 8;
        rs1 = int'(instr[15:8]) % 8;
        rs2 = int'(instr[7:0]) % 8;
        imm = int'(instr[7:0]);
        off = int'(instr[23:16]);
        if (off > 127) off = off - 256;
        a = m_regs[rs1];
        b = m_regs[rs2];
        wr = 1'b0; taken = 1'b0; res = 0;
        case (op)
            0: begin wr = 1'b1; res = imm; end
            1: begin wr = 1'b1; res = b; end
            2: begin wr = 1'b1; res = (a + b) % 256; end
            3: begin wr = 1'b1; res = (a - b + 256) % 256; end
            4: begin wr = 1'b1; res = a & b; end
            5: begin wr = 1'b1; res = a | b; end
            6: taken = 1'b1;
            7: taken = (a == b);
            default: ;
        endcase
        if (wr) m_regs[rd] = res;
        m_pc = m_pc + 32'd4 + (taken ? 32'(off * 4) : 32'd0);
    endtask

    task automatic compare_all();
        chk("pc", PC, m_pc);
        for (int i = 0; i < 8; i++)
            chk($sformatf("r%0d", i), {24'h0, dut.u_rf.regs_q[i]}, 32'(m_regs[i]));
    endtask

    // Apply one instruction (or reset) across one rising edge and check state
    task automatic step(input logic [31:0] instr, input logic rst);
        @(negedge CLK);
        INSTRUCTION = instr;
        RESET       = rst;
        @(posedge CLK);
        model(instr, rst);
        #1;
        compare_all();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(NOP, 1'b0);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [7:0]  rop;
        RESET       = 1'b1;
        INSTRUCTION = 32'h0;
        m_pc        = RESET_PC;
        for (int i = 0; i < 8; i++) m_regs[i] = 0;

        vecs[0]  = '{32'h0004_0005, 32'h04, 4, 8'h05};
        vecs[1]  = '{32'h0002_0009, 32'h08, 2, 8'h09};
        vecs[2]  = '{32'h0206_0402, 32'h0C, 6, 8'h0E};
        vecs[3]  = '{32'h0001_0003, 32'h10, 1, 8'h03};
        vecs[4]  = '{32'h0002_0009, 32'h14, 2, 8'h09};
        vecs[5]  = '{32'h0300_0102, 32'h18, 0, 8'hFA};
        vecs[6]  = '{32'h0003_00FF, 32'h1C, 3, 8'hFF};
        vecs[7]  = '{32'h0204_0303, 32'h20, 4, 8'hFE};
        vecs[8]  = '{32'h0001_00CC, 32'h24, 1, 8'hCC};
        vecs[9]  = '{32'h0002_00AA, 32'h28, 2, 8'hAA};
        vecs[10] = '{32'h0403_0102, 32'h2C, 3, 8'h88};
        vecs[11] = '{32'h0504_0102, 32'h30, 4, 8'hEE};
        vecs[12] = '{32'h0105_0002, 32'h34, 5, 8'hAA};

        // Reset with a loadi presented: nothing may be written
        step(32'h0007_0033, 1'b1);
        chk("reset_pc", PC, 32'h0);
        step(NOP, 1'b0);
        chk("pc_after_reset_edge", PC, 32'h4);

        // Directed arithmetic / logic table
        step(NOP, 1'b1);
        foreach (vecs[k]) begin
            step(vecs[k].instr, 1'b0);
            chk($sformatf("vec%0d_pc", k), PC, vecs[k].exp_pc);
            chk($sformatf("vec%0d_reg", k), {24'h0, dut.u_rf.regs_q[vecs[k].reg_idx]},
                {24'h0, vecs[k].exp_val});
        end

        // Self-source write uses pre-edge operands: R1=0x81, add R1,R1,R1 -> 0x02
        step(32'h0001_0081, 1'b0);
        step(32'h0201_0101, 1'b0);
        chk("self_add", {24'h0, dut.u_rf.regs_q[1]}, 32'h02);

        // beq taken at 0x10
        step(NOP, 1'b1);
        nops(4);
        step(32'h0702_0101, 1'b0);
        chk("beq_taken", PC, 32'h1C);

        // beq not taken at 0x10, then j backwards from 0x20
        step(NOP, 1'b1);
        step(32'h0001_0001, 1'b0);
        nops(3);
        step(32'h0702_0102, 1'b0);
        chk("beq_not_taken", PC, 32'h14);
        nops(3);
        chk("pc_before_j", PC, 32'h20);
        step(32'h06FE_0000, 1'b0);
        chk("j_back", PC, 32'h1C);
        chk("j_no_write_r1", {24'h0, dut.u_rf.regs_q[1]}, 32'h01);

        // Mid-run reset at 0x18 with a loadi presented, then undefined opcode
        step(NOP, 1'b1);
        step(32'h0007_0077, 1'b0);
        nops(5);
        chk("pc_before_midreset", PC, 32'h18);
        step(32'h0007_0055, 1'b1);
        chk("midreset_pc", PC, 32'h0);
        chk("midreset_r7", {24'h0, dut.u_rf.regs_q[7]}, 32'h00);
        step(32'h5A07_0011, 1'b0);
        chk("undef_pc", PC, 32'h4);
        chk("undef_r7", {24'h0, dut.u_rf.regs_q[7]}, 32'h00);

        // PC wraps modulo 2^32 in both directions
        step(NOP, 1'b1);
        step(32'h0680_0000, 1'b0);
        chk("wrap_down", PC, 32'hFFFF_FE04);
        nops(1);
        step(32'h067F_0000, 1'b0);
        chk("wrap_up", PC, 32'h0000_0008);

        // Randomized instructions with occasional reset
        for (int n = 0; n < 500; n++) begin
            rnd = $urandom();
            if ($urandom_range(0, 9) == 0) rop = 8'($urandom_range(8, 255));
            else rop = 8'($urandom_range(0, 7));
            rnd[31:24] = rop;
            step(rnd, ($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 CLK  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 RESET  input  1  reset; one clock, synchronous, active-high.
REQ-004 PC  output  32  address of the current instruction, byte-addressed; SHALL be driven directly from the PC register.
REQ-005 INSTRUCTION  input  32  instruction word at PC, supplied combinationally by external memory within the same cycle.

Function
REQ-006 Instruction fields SHALL be decoded as follows:
- OP = INSTRUCTION[31:24].
- RD/OFFSET = [23:16].
- RS1 = [15:8].
- RS2/IMM = [7:0].
- Register indices SHALL use the low 3 bits of each field.
REQ-007 The register file SHALL contain 8 registers of 8 bits each (R0-R7), with two combinational read ports and one write port clocked on the rising edge.
REQ-008 Opcodes SHALL be:
- 0x00 loadi: RD<=IMM.
- 0x01 mov: RD<=R[RS2].
- 0x02 add: RD<=R[RS1]+R[RS2].
- 0x03 sub: RD<=R[RS1]-R[RS2].
- 0x04 and: RD<=R[RS1]&R[RS2].
- 0x05 or: RD<=R[RS1]|R[RS2].
- 0x06 j.
- 0x07 beq.
REQ-009 add and sub SHALL be 8-bit two's complement, with result modulo 256 and no carry or overflow outputs.
REQ-010 Each instruction SHALL complete in exactly one cycle: operands are read combinationally and the result is written at the next rising edge.
REQ-011 Sequential PC update: PC SHALL become PC+4 at each rising edge when RESET=0 and no taken branch or jump.
REQ-012 j SHALL set PC <= PC+4+(sign-extended OFFSET<<2) and SHALL NOT write any register.
REQ-013 beq SHALL set PC <= PC+4+(sign-extended OFFSET<<2) when R[RS1]==R[RS2], else PC+4; it SHALL NOT write any register.
REQ-014 Opcodes 0x08-0xFF SHALL execute as NOP: no register write and PC <= PC+4.
REQ-015 Reading a register in the cycle it is written SHALL return the old value, with no bypass needed given single-cycle execution.
REQ-016 PC arithmetic SHALL wrap modulo 2^32.
REQ-017 Writing the same register as a source (e.g. add R1,R1,R1) SHALL use pre-edge operand values.

Reset
REQ-018 On a rising edge with RESET=1, PC SHALL be set to RESET_PC and R0-R7 SHALL be cleared to 8'h00.
REQ-019 No register write or branch SHALL occur on a reset edge.
REQ-020 RESET asserted mid-program SHALL abandon the current instruction; the first instruction after deassertion SHALL be fetched at RESET_PC.
REQ-021 Outputs SHALL be undefined only before the first reset edge; a bench SHALL assert RESET for at least one rising edge.

Structure
REQ-022 A shared package cpu_pkg SHALL hold the opcode constants (OP_LOADI..OP_BEQ) and field-position constants.
REQ-023 The register file SHALL be a single sub-module reg_file_8x8, with ports clk, reset, wr_en, wr_addr[2:0], wr_data[7:0], rd_addr1, rd_addr2, rd_data1, rd_data2.
REQ-024 ALU, decode and PC logic SHALL be inline in cpu, with a total implementation of 120-400 lines.
REQ-025 The register array SHALL be reachable hierarchically for verification probes.

Verification
REQ-026 Reset: RESET=1 for one edge, then 0 -> PC=0x0, R0-R7=0x00; the next edge gives PC=0x4.
REQ-027 Arithmetic: program 0x00040005, 0x00020009, 0x02060402 at 0/4/8 -> R4=5, R2=9, R6=14 (0x0E); PC=12 after the third edge.
REQ-028 Wrap: loadi R1,3; loadi R2,9; sub R0,R1,R2 -> R0=0xFA; loadi R3,0xFF; add R4,R3,R3 -> R4=0xFE.
REQ-029 Logic/move: R1=0xCC, R2=0xAA; and R3,R1,R2 -> 0x88; or R4,R1,R2 -> 0xEE; mov R5,R2 -> 0xAA.
REQ-030 Control: beq R1,R1 with OFFSET=2 at PC=0x10 -> PC=0x1C; beq with unequal operands -> PC=0x14; j OFFSET=0xFE at PC=0x20 -> PC=0x1C; no register changes.
REQ-031 Mid-run reset: assert RESET at PC=0x18 for one edge -> PC=0x0 and all registers 0x00; an undefined opcode 0x5A -> PC+4 and no register change.
